// File: rtl/ps2_keymap_ctrl_if.sv
// Byte-level handshake bundle between the keymap controller and the PS/2 serial link.
interface ps2_keymap_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;

  modport master (
    output cmd_valid, cmd_data, rx_ready,
    input  cmd_ready, rx_valid, rx_data
  );

  modport slave (
    input  cmd_valid, cmd_data, rx_ready,
    output cmd_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/ps2_keymap_ctrl.sv
// PS/2 keyboard front end: brings the keyboard up (reset, enable, scan set 2), then decodes
// set-2 make/break/extended codes through a writable keymap into active-low joypad buttons.
module ps2_keymap_ctrl #(
  parameter int NUM_BTN     = 8,
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int MAX_RETRY   = 3,
  parameter logic [9*NUM_BTN-1:0] KEYMAP =
    {9'h00D, 9'h00E, 9'h029, 9'h076, 9'h01B, 9'h01D, 9'h01C, 9'h023}
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       init_req,
  ps2_keymap_ctrl_if.master          link,
  input  logic                       map_we,
  input  logic [$clog2(NUM_BTN)-1:0] map_idx,
  input  logic [8:0]                 map_code,
  output logic [NUM_BTN-1:0]         btn,
  output logic                       btn_change,
  output logic                       init_done,
  output logic                       init_error
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  // Issue states drive a command byte; W_ACK / W_BAT wait for the keyboard's answer.
  typedef enum logic [2:0] {
    S_RST, S_EN, S_SCAN, S_SCAN2, W_ACK, W_BAT, S_RUN, S_ERR
  } state_t;

  state_t               state_q, state_d;
  state_t               step_q, step_d;
  logic [RTY_W-1:0]     retry_q, retry_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [7:0]           cmd_data_q, cmd_data_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 ext_q, ext_d;
  logic                 brk_q, brk_d;
  logic [NUM_BTN-1:0]   btn_q, btn_d;
  logic                 btn_change_q, btn_change_d;
  logic [8:0]           keymap_q [NUM_BTN];
  logic [8:0]           keymap_d [NUM_BTN];
  logic                 vld_p1_q, vld_p1_d;
  logic [NUM_BTN-1:0]   match_p1_q, match_p1_d;
  logic                 brk_p1_q, brk_p1_d;

  logic rx_hs;
  logic cmd_hs;
  logic fail;

  assign rx_hs  = link.rx_valid && rx_ready_q;
  assign cmd_hs = cmd_valid_q && link.cmd_ready;

  function automatic logic [7:0] step_byte(input state_t s);
    case (s)
      S_RST:   step_byte = 8'hFF;
      S_EN:    step_byte = 8'hF4;
      S_SCAN:  step_byte = 8'hF0;
      S_SCAN2: step_byte = 8'h02;
      default: step_byte = 8'h00;
    endcase
  endfunction

  function automatic state_t step_after(input state_t s);
    case (s)
      S_EN:    step_after = S_SCAN;
      S_SCAN:  step_after = S_SCAN2;
      default: step_after = S_RUN;
    endcase
  endfunction

  function automatic logic is_ignored(input logic [7:0] b);
    is_ignored = (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
                 (b == 8'h00) || (b == 8'hFF);
  endfunction

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    retry_d     = retry_q;
    wait_cnt_d  = wait_cnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    rx_ready_d  = 1'b1;
    ext_d       = ext_q;
    brk_d       = brk_q;
    btn_d       = btn_q;
    vld_p1_d    = 1'b0;
    match_p1_d  = match_p1_q;
    brk_p1_d    = brk_p1_q;
    keymap_d    = keymap_q;
    fail        = 1'b0;

    // ---- stage p1 -> btn: apply the code matched on the previous edge
    if (vld_p1_q) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (match_p1_q[i]) btn_d[i] = brk_p1_q;
      end
    end

    case (state_q)
      S_RST, S_EN, S_SCAN, S_SCAN2: begin
        cmd_valid_d = 1'b1;
        cmd_data_d  = step_byte(state_q);
        if (cmd_hs) begin
          cmd_valid_d = 1'b0;
          state_d     = W_ACK;
          step_d      = state_q;
          wait_cnt_d  = '0;
        end
      end
      W_ACK, W_BAT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (rx_hs) begin
          if (state_q == W_ACK && link.rx_data == 8'hFA) begin
            if (step_q == S_RST) begin
              state_d    = W_BAT;
              wait_cnt_d = '0;
            end else begin
              state_d = step_after(step_q);
              retry_d = '0;
            end
          end else if (state_q == W_BAT && link.rx_data == 8'hAA) begin
            state_d = S_EN;
            retry_d = '0;
          end else begin
            fail = 1'b1;
          end
        end else if (wait_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          fail = 1'b1;
        end
        if (fail) begin
          if (retry_q == RTY_W'(MAX_RETRY)) begin
            state_d = S_ERR;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = step_q;
          end
        end
      end
      S_RUN: begin
        // ---- rx -> stage p1: match against the map as it stands before this edge
        if (rx_hs) begin
          if (link.rx_data == 8'hE0) begin
            ext_d = 1'b1;
          end else if (link.rx_data == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (!is_ignored(link.rx_data)) begin
              for (int i = 0; i < NUM_BTN; i++) begin
                match_p1_d[i] = (keymap_q[i] == {ext_q, link.rx_data});
              end
              brk_p1_d = brk_q;
              vld_p1_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    if (init_req) begin
      state_d     = S_RST;
      retry_d     = '0;
      cmd_valid_d = 1'b0;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
      btn_d       = '1;
      vld_p1_d    = 1'b0;
    end

    if (map_we && (32'(map_idx) < NUM_BTN)) keymap_d[map_idx] = map_code;

    btn_change_d = (btn_d != btn_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RST;
      step_q       <= S_RST;
      retry_q      <= '0;
      wait_cnt_q   <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_data_q   <= 8'h00;
      rx_ready_q   <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      btn_q        <= '1;
      btn_change_q <= 1'b0;
      vld_p1_q     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) keymap_q[i] <= KEYMAP[9*i +: 9];
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      retry_q      <= retry_d;
      wait_cnt_q   <= wait_cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_data_q   <= cmd_data_d;
      rx_ready_q   <= rx_ready_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      btn_q        <= btn_d;
      btn_change_q <= btn_change_d;
      vld_p1_q     <= vld_p1_d;
      keymap_q     <= keymap_d;
    end
  end

  always_ff @(posedge clk) begin
    match_p1_q <= match_p1_d;
    brk_p1_q   <= brk_p1_d;
  end

  assign link.cmd_valid = cmd_valid_q;
  assign link.cmd_data  = cmd_data_q;
  assign link.rx_ready  = rx_ready_q;
  assign btn            = btn_q;
  assign btn_change     = btn_change_q;
  assign init_done      = (state_q == S_RUN);
  assign init_error     = (state_q == S_ERR);

endmodule

// File: tb/tb_ps2_keymap_ctrl.sv
// Directed bench for ps2_keymap_ctrl with a transaction-level reference model checked every cycle.
module tb_ps2_keymap_ctrl;
  localparam int NUM_BTN     = 8;
  localparam int ACK_TIMEOUT = 20;
  localparam int MAX_RETRY   = 3;
  localparam logic [9*NUM_BTN-1:0] KM_DEF =
    {9'h00D, 9'h00E, 9'h029, 9'h076, 9'h01B, 9'h01D, 9'h01C, 9'h023};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               init_req;
  logic               map_we;
  logic [2:0]         map_idx;
  logic [8:0]         map_code;
  logic [NUM_BTN-1:0] btn;
  logic               btn_change;
  logic               init_done;
  logic               init_error;

  ps2_keymap_ctrl_if link();

  ps2_keymap_ctrl #(
    .NUM_BTN(NUM_BTN), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .init_req(init_req), .link(link),
    .map_we(map_we), .map_idx(map_idx), .map_code(map_code),
    .btn(btn), .btn_change(btn_change), .init_done(init_done), .init_error(init_error)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cmd_for(input int s);
    case (s)
      0:       cmd_for = 8'hFF;
      1:       cmd_for = 8'hF4;
      2:       cmd_for = 8'hF0;
      default: cmd_for = 8'h02;
    endcase
  endfunction

  // Reference model: init progress as a step index 0..3 (4 = running), plus decoder and map.
  int                 m_step, m_retry, m_wait;
  bit                 m_sending, m_need_bat, m_err, m_ready, m_ext, m_brk;
  bit                 m_pend_v, m_pend_brk, m_chg;
  logic [NUM_BTN-1:0] m_btn, m_pend_mask;
  logic [8:0]         km [NUM_BTN];
  logic [7:0]         cmd_log [$];

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_step = 0; m_retry = 0; m_wait = 0;
      m_sending = 1; m_need_bat = 0; m_err = 0; m_ready = 0; m_ext = 0; m_brk = 0;
      m_pend_v = 0; m_pend_brk = 0; m_chg = 0; m_btn = '1; m_pend_mask = '0;
      for (int i = 0; i < NUM_BTN; i++) km[i] = KM_DEF[9*i +: 9];
    end else begin
      logic               rx_hs, cmd_hs, fail;
      logic [NUM_BTN-1:0] nb;
      rx_hs  = link.rx_valid && m_ready;
      cmd_hs = link.cmd_valid && link.cmd_ready;
      fail   = 0;
      nb     = m_btn;
      if (m_pend_v)
        for (int i = 0; i < NUM_BTN; i++) if (m_pend_mask[i]) nb[i] = m_pend_brk;
      m_pend_v = 0;
      if (init_req) begin
        m_step = 0; m_sending = 1; m_need_bat = 0; m_err = 0; m_retry = 0;
        m_ext = 0; m_brk = 0; nb = '1;
      end else if (!m_err && m_step < 4) begin
        if (m_sending) begin
          if (cmd_hs) begin
            check("cmd_byte", link.cmd_data, cmd_for(m_step));
            cmd_log.push_back(link.cmd_data);
            m_sending = 0;
            m_wait = 0;
          end
        end else begin
          if (rx_hs) begin
            if (!m_need_bat && link.rx_data == 8'hFA) begin
              if (m_step == 0) begin m_need_bat = 1; m_wait = 0; end
              else begin m_step++; m_retry = 0; m_sending = 1; end
            end else if (m_need_bat && link.rx_data == 8'hAA) begin
              m_need_bat = 0; m_step = 1; m_retry = 0; m_sending = 1;
            end else fail = 1;
          end else if (m_wait == ACK_TIMEOUT - 1) fail = 1;
          else m_wait++;
          if (fail) begin
            if (m_retry == MAX_RETRY) m_err = 1;
            else begin m_retry++; m_sending = 1; m_need_bat = 0; end
          end
        end
      end else if (!m_err && rx_hs) begin
        case (link.rx_data)
          8'hE0: m_ext = 1;
          8'hF0: m_brk = 1;
          8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF: begin m_ext = 0; m_brk = 0; end
          default: begin
            for (int i = 0; i < NUM_BTN; i++) m_pend_mask[i] = (km[i] == {m_ext, link.rx_data});
            m_pend_brk = m_brk; m_pend_v = 1; m_ext = 0; m_brk = 0;
          end
        endcase
      end
      if (map_we && map_idx < NUM_BTN) km[map_idx] = map_code;
      m_chg  = (nb != m_btn);
      m_btn  = nb;
      m_ready = 1;
    end
  end

  // Per-cycle comparison of every observable output against the model.
  initial forever begin
    @(posedge clk);
    #2;
    if (reset_n) begin
      check("btn", btn, m_btn);
      check("btn_change", btn_change, m_chg);
      check("init_done", init_done, (m_step == 4) && !m_err);
      check("init_error", init_error, m_err);
      check("rx_ready", link.rx_ready, m_ready);
      check("cmd_valid_outside_send", link.cmd_valid & ~(m_sending && m_step < 4 && !m_err), 0);
      if (btn_change) pulses++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cmd(input int bound);
    int n0;
    int k;
    n0 = cmd_log.size();
    k  = 0;
    while (cmd_log.size() == n0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("cmd_arrives", cmd_log.size() > n0, 1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    link.rx_valid = 1'b1;
    link.rx_data  = b;
    @(negedge clk);
    link.rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n0;
    int p0;
    int cnt;
    reset_n = 0; init_req = 0; map_we = 0; map_idx = '0; map_code = '0;
    link.cmd_ready = 0; link.rx_valid = 0; link.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_btn", btn, 8'hFF);
    check("rst_btn_change", btn_change, 0);
    check("rst_cmd_valid", link.cmd_valid, 0);
    check("rst_cmd_data", link.cmd_data, 8'h00);
    check("rst_rx_ready", link.rx_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_error", init_error, 0);
    reset_n = 1;
    link.cmd_ready = 1;
    @(negedge clk);
    check("rx_ready_after_rst", link.rx_ready, 1);

    // Normal bring-up.
    wait_cmd(10); send_rx(8'hFA); send_rx(8'hAA);
    wait_cmd(10); send_rx(8'hFA);
    wait_cmd(10); send_rx(8'hFA);
    wait_cmd(10); send_rx(8'hFA);
    settle();
    check("init_cmd_count", cmd_log.size(), 4);
    check("init_cmd0", cmd_log[0], 8'hFF);
    check("init_cmd1", cmd_log[1], 8'hF4);
    check("init_cmd2", cmd_log[2], 8'hF0);
    check("init_cmd3", cmd_log[3], 8'h02);
    check("init_done_lit", init_done, 1);
    check("init_btn_lit", btn, 8'hFF);

    // Make, typematic repeat, break of W (up).
    p0 = pulses;
    send_rx(8'h1D); settle();
    check("up_press_btn", btn, 8'hFB);
    check("up_press_pulse", pulses - p0, 1);
    send_rx(8'h1D); settle();
    check("up_repeat_pulse", pulses - p0, 1);
    send_rx(8'hF0); send_rx(8'h1D); settle();
    check("up_release_btn", btn, 8'hFF);

    // Extended up arrow: unmapped, then remapped onto entry 2.
    send_rx(8'hE0); send_rx(8'h75); settle();
    check("ext_unmapped_btn", btn, 8'hFF);
    map_we = 1; map_idx = 3'd2; map_code = 9'h175;
    @(negedge clk);
    map_we = 0;
    send_rx(8'hE0); send_rx(8'h75); settle();
    check("ext_mapped_btn", btn, 8'hFB);

    // Map write coinciding with a decode: decode sees the old map.
    map_we = 1; map_idx = 3'd0; map_code = 9'h01C;
    link.rx_valid = 1; link.rx_data = 8'h1C;
    @(negedge clk);
    map_we = 0; link.rx_valid = 0;
    settle();
    check("same_cycle_btn", btn, 8'hF9);
    send_rx(8'hF0); send_rx(8'h1C); settle();
    check("dual_release_btn", btn, 8'hFB);
    map_we = 1; map_idx = 3'd0; map_code = 9'h023;
    @(negedge clk);
    map_we = 0;

    // Hold D, then restart the init sequence.
    send_rx(8'h23); settle();
    check("d_press_btn", btn, 8'hFA);
    init_req = 1;
    @(negedge clk);
    init_req = 0;
    check("restart_btn", btn, 8'hFF);
    check("restart_done", init_done, 0);
    wait_cmd(10);
    check("restart_cmd", cmd_log[cmd_log.size()-1], 8'hFF);

    // Enable step never answered: original plus MAX_RETRY resends, then error.
    send_rx(8'hFA); send_rx(8'hAA);
    n0 = cmd_log.size();
    for (int r = 0; r <= MAX_RETRY; r++) wait_cmd(ACK_TIMEOUT + 10);
    repeat (ACK_TIMEOUT + 10) @(negedge clk);
    cnt = 0;
    for (int i = n0; i < cmd_log.size(); i++) if (cmd_log[i] == 8'hF4) cnt++;
    check("timeout_f4_count", cnt, MAX_RETRY + 1);
    check("timeout_total", cmd_log.size() - n0, MAX_RETRY + 1);
    check("timeout_error", init_error, 1);
    check("timeout_cmd_valid", link.cmd_valid, 0);

    // Resend request during scan-set step.
    init_req = 1;
    @(negedge clk);
    init_req = 0;
    check("err_cleared", init_error, 0);
    wait_cmd(10); send_rx(8'hFA); send_rx(8'hAA);
    wait_cmd(10); send_rx(8'hFA);
    wait_cmd(10);
    n0 = cmd_log.size();
    send_rx(8'hFE);
    wait_cmd(10); send_rx(8'hFA);
    wait_cmd(10); send_rx(8'hFA);
    settle();
    check("fe_resend", cmd_log[n0], 8'hF0);
    check("fe_advance", cmd_log[n0+1], 8'h02);
    check("fe_done", init_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
